// File: rtl/axis_block_detector.sv
// Per-channel AXI-Stream block flags, consecutive-stall timers and a sticky kernel
// deadlock detector feeding the deadlock monitor in the sim/debug wrapper.
module axis_block_detector #(
  parameter int unsigned          NUM_CH   = 2,
  parameter logic [NUM_CH-1:0]    DIR_MASK = NUM_CH'(1),
  parameter int unsigned          CNT_W    = 16,
  parameter int unsigned          THRESH   = 1024,
  localparam int unsigned         FCH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              kernel_monitor_clock,
  input  logic              kernel_monitor_reset,
  input  logic [NUM_CH-1:0] ch_tvalid,
  input  logic [NUM_CH-1:0] ch_tready,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              clear,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic [NUM_CH-1:0] ch_stalled,
  output logic              deadlock,
  output logic              deadlock_pulse,
  output logic [FCH_W-1:0]  first_ch
);

  localparam int unsigned      THR_EFF = (THRESH == 0) ? 1 : THRESH;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_MONITOR  = 2'd0,
    ST_SUSPECT  = 2'd1,
    ST_DEADLOCK = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q [NUM_CH];
  logic [CNT_W-1:0]    cnt_d [NUM_CH];
  logic [NUM_CH-1:0]   blk_q, blk_d;
  logic [NUM_CH-1:0]   ch_stalled_q, ch_stalled_d;
  logic                deadlock_q, deadlock_d;
  logic                deadlock_pulse_q, deadlock_pulse_d;
  logic [FCH_W-1:0]    first_ch_q, first_ch_d;

  logic [NUM_CH-1:0]   raw_blk;
  logic [NUM_CH-1:0]   en_stalled;
  logic                all_en_stalled;
  logic                first_sat;
  logic [FCH_W-1:0]    lowest;

  always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
    if (kernel_monitor_reset) begin
      state_q          <= ST_MONITOR;
      blk_q            <= '0;
      ch_stalled_q     <= '0;
      deadlock_q       <= 1'b0;
      deadlock_pulse_q <= 1'b0;
      first_ch_q       <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= '0;
    end else begin
      state_q          <= state_d;
      blk_q            <= blk_d;
      ch_stalled_q     <= ch_stalled_d;
      deadlock_q       <= deadlock_d;
      deadlock_pulse_q <= deadlock_pulse_d;
      first_ch_q       <= first_ch_d;
      for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    state_d          = state_q;
    first_ch_d       = first_ch_q;
    deadlock_pulse_d = 1'b0;
    raw_blk          = '0;
    ch_stalled_d     = '0;
    lowest           = '0;

    // Consumer ports block when ready waits on valid; producer ports the reverse.
    for (int i = 0; i < int'(NUM_CH); i++) begin
      raw_blk[i] = DIR_MASK[i] ? (ch_tready[i] & ~ch_tvalid[i])
                               : (ch_tvalid[i] & ~ch_tready[i]);
      cnt_d[i]   = raw_blk[i] ? ((cnt_q[i] == CNT_MAX) ? CNT_MAX : cnt_q[i] + CNT_W'(1))
                              : '0;
      ch_stalled_d[i] = (33'(cnt_d[i]) >= 33'(THR_EFF));
    end
    blk_d = raw_blk;

    en_stalled     = ch_en & ch_stalled_q;
    all_en_stalled = (ch_en != '0) && ((ch_en & ~ch_stalled_q) == '0);
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (en_stalled[i]) lowest = FCH_W'(i);
    end
    first_sat = (cnt_q[first_ch_q] == CNT_MAX);

    case (state_q)
      ST_MONITOR: begin
        if (en_stalled != '0) begin
          state_d    = ST_SUSPECT;
          first_ch_d = lowest;
        end
      end
      ST_SUSPECT: begin
        if (all_en_stalled || first_sat) begin
          state_d          = ST_DEADLOCK;
          deadlock_pulse_d = 1'b1;
        end else if (en_stalled == '0) begin
          state_d = ST_MONITOR;
        end
      end
      ST_DEADLOCK: state_d = ST_DEADLOCK;
      default:     state_d = ST_MONITOR;
    endcase

    // Clear overrides any simultaneous stall or deadlock event; block flags keep tracking.
    if (clear) begin
      state_d          = ST_MONITOR;
      first_ch_d       = '0;
      deadlock_pulse_d = 1'b0;
      ch_stalled_d     = '0;
      for (int i = 0; i < int'(NUM_CH); i++) cnt_d[i] = '0;
    end

    deadlock_d = (state_d == ST_DEADLOCK);
  end

  assign axis_block_sigs = blk_q;
  assign ch_stalled      = ch_stalled_q;
  assign deadlock        = deadlock_q;
  assign deadlock_pulse  = deadlock_pulse_q;
  assign first_ch        = first_ch_q;

endmodule

// File: tb/tb_axis_block_detector.sv
// Self-checking bench for axis_block_detector: run-length reference model, directed
// scenarios with literal expectations, then randomized channel traffic.
module tb_axis_block_detector;

  localparam int unsigned NUM_CH   = 2;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned THRESH   = 8;
  localparam int          SAT_RUN  = 15;
  localparam logic [1:0]  DIR_MASK = 2'b01;

  localparam int BLK  = 0;
  localparam int XFER = 1;
  localparam int IDLE = 2;
  localparam int OPP  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ch_tvalid, ch_tready, ch_en;
  logic       clear;
  logic [1:0] axis_block_sigs, ch_stalled;
  logic       deadlock, deadlock_pulse;
  logic [0:0] first_ch;

  int checks = 0;
  int errors = 0;

  axis_block_detector #(
    .NUM_CH  (NUM_CH),
    .DIR_MASK(DIR_MASK),
    .CNT_W   (CNT_W),
    .THRESH  (THRESH)
  ) dut (
    .kernel_monitor_clock(clk),
    .kernel_monitor_reset(rst),
    .ch_tvalid           (ch_tvalid),
    .ch_tready           (ch_tready),
    .ch_en               (ch_en),
    .clear               (clear),
    .axis_block_sigs     (axis_block_sigs),
    .ch_stalled          (ch_stalled),
    .deadlock            (deadlock),
    .deadlock_pulse      (deadlock_pulse),
    .first_ch            (first_ch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the clock edge.
  logic [1:0] s_vld, s_rdy, s_en;
  logic       s_clr;
  always @(posedge clk) begin
    s_vld <= ch_tvalid;
    s_rdy <= ch_tready;
    s_en  <= ch_en;
    s_clr <= clear;
  end

  // Reference model: run lengths of consecutive blocked cycles and a phase variable.
  int         m_run [2];
  int         m_phase;
  int         m_first;
  logic [1:0] m_abs, m_st;
  logic       m_dl, m_pulse;

  initial begin
    int         old_run [2];
    logic [1:0] blk, old_st, en_st;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_run[0] = 0; m_run[1] = 0;
        m_phase = 0; m_first = 0;
        m_abs = '0; m_st = '0; m_dl = 1'b0; m_pulse = 1'b0;
      end else begin
        for (int i = 0; i < 2; i++)
          blk[i] = DIR_MASK[i] ? (s_rdy[i] && !s_vld[i]) : (s_vld[i] && !s_rdy[i]);
        m_abs = blk;
        old_st = m_st;
        old_run[0] = m_run[0]; old_run[1] = m_run[1];
        m_pulse = 1'b0;
        if (s_clr) begin
          m_run[0] = 0; m_run[1] = 0;
          m_st = '0; m_phase = 0; m_first = 0;
        end else begin
          for (int i = 0; i < 2; i++) begin
            m_run[i] = blk[i] ? ((m_run[i] < 1000) ? m_run[i] + 1 : 1000) : 0;
            m_st[i]  = (m_run[i] >= int'(THRESH));
          end
          en_st = s_en & old_st;
          if (m_phase == 0) begin
            if (en_st != 2'b00) begin
              m_phase = 1;
              m_first = en_st[0] ? 0 : 1;
            end
          end else if (m_phase == 1) begin
            if ((s_en != 2'b00 && (s_en & ~old_st) == 2'b00) || old_run[m_first] >= SAT_RUN) begin
              m_phase = 2;
              m_pulse = 1'b1;
            end else if (en_st == 2'b00) begin
              m_phase = 0;
            end
          end
        end
        m_dl = (m_phase == 2);
      end
      chk("cmp_abs",   32'(axis_block_sigs), int'(m_abs));
      chk("cmp_stall", 32'(ch_stalled),      int'(m_st));
      chk("cmp_dl",    32'(deadlock),        int'(m_dl));
      chk("cmp_pulse", 32'(deadlock_pulse),  int'(m_pulse));
      chk("cmp_first", 32'(first_ch),        m_first);
    end
  end

  task automatic set_ch(input int ch, input int mode);
    logic v, r;
    case (mode)
      BLK:     begin v = !DIR_MASK[ch]; r = DIR_MASK[ch];  end
      XFER:    begin v = 1'b1;          r = 1'b1;          end
      OPP:     begin v = DIR_MASK[ch];  r = !DIR_MASK[ch]; end
      default: begin v = 1'b0;          r = 1'b0;          end
    endcase
    ch_tvalid[ch] = v;
    ch_tready[ch] = r;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  int mode [2];
  int hold [2];

  initial begin
    rst = 1'b1; clear = 1'b0; ch_en = 2'b11;
    ch_tvalid = '0; ch_tready = '0;
    tick(2);
    chk("rst_abs",   32'(axis_block_sigs), 0);
    chk("rst_stall", 32'(ch_stalled),      0);
    chk("rst_dl",    32'(deadlock),        0);
    chk("rst_pulse", 32'(deadlock_pulse),  0);
    chk("rst_first", 32'(first_ch),        0);
    #1 rst = 1'b0;
    tick(2);

    // Single channel reaches the stall threshold.
    set_ch(0, BLK); set_ch(1, IDLE);
    tick(1);
    chk("t1_abs", 32'(axis_block_sigs), 1);
    tick(6);
    chk("t1_stall7", 32'(ch_stalled), 0);
    tick(1);
    chk("t1_stall8", 32'(ch_stalled), 1);
    tick(1);
    chk("t1_suspect", 32'(m_phase), 1);
    chk("t1_dl", 32'(deadlock), 0);
    set_ch(0, IDLE);
    tick(1);
    chk("t1_drop", 32'(ch_stalled), 0);
    tick(2);
    chk("t1_monitor", 32'(m_phase), 0);

    // Seven blocked cycles then a transfer never stalls.
    for (int r = 0; r < 3; r++) begin
      set_ch(0, BLK);
      tick(7);
      chk("t2_nostall", 32'(ch_stalled), 0);
      set_ch(0, XFER);
      tick(1);
    end
    chk("t2_dl", 32'(deadlock), 0);

    // Both channels blocked: all enabled stalled -> deadlock.
    set_ch(0, BLK); set_ch(1, BLK);
    tick(8);
    chk("t3_stall", 32'(ch_stalled), 3);
    tick(1);
    chk("t3_dl_pre", 32'(deadlock), 0);
    tick(1);
    chk("t3_dl",    32'(deadlock), 1);
    chk("t3_pulse", 32'(deadlock_pulse), 1);
    chk("t3_first", 32'(first_ch), 0);
    tick(1);
    chk("t3_pulse_off", 32'(deadlock_pulse), 0);
    chk("t3_sticky",    32'(deadlock), 1);

    // Clear in DEADLOCK with both still blocked.
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("t5_stall", 32'(ch_stalled), 0);
    chk("t5_dl",    32'(deadlock), 0);
    chk("t5_abs",   32'(axis_block_sigs), 3);
    tick(8);
    chk("t5_restall", 32'(ch_stalled), 3);
    tick(2);
    chk("t5_redl",    32'(deadlock), 1);
    chk("t5_repulse", 32'(deadlock_pulse), 1);

    // Only channel 1 enabled and blocked.
    ch_en = 2'b10; set_ch(0, IDLE); set_ch(1, BLK);
    pulse_clear();
    tick(8);
    chk("t4_stall", 32'(ch_stalled), 2);
    tick(2);
    chk("t4_dl",    32'(deadlock), 1);
    chk("t4_first", 32'(first_ch), 1);

    // Channel 0 alone blocked until its counter saturates.
    ch_en = 2'b11; set_ch(0, BLK); set_ch(1, IDLE);
    pulse_clear();
    tick(15);
    chk("t6_dl15",   32'(deadlock), 0);
    chk("t6_stall",  32'(ch_stalled), 1);
    tick(1);
    chk("t6_dl16",   32'(deadlock), 1);
    chk("t6_pulse",  32'(deadlock_pulse), 1);
    chk("t6_first",  32'(first_ch), 0);
    chk("t6_mfirst", 32'(m_first), 0);

    // Reset asserted mid-stall.
    pulse_clear();
    set_ch(0, BLK); set_ch(1, BLK);
    tick(9);
    #2 rst = 1'b1;
    #1;
    chk("t7_abs",   32'(axis_block_sigs), 0);
    chk("t7_stall", 32'(ch_stalled), 0);
    chk("t7_dl",    32'(deadlock), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    tick(1);
    chk("t7_abs_after",   32'(axis_block_sigs), 3);
    chk("t7_stall_after", 32'(ch_stalled), 0);

    // Randomized traffic with held per-channel patterns.
    hold[0] = 0; hold[1] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (hold[i] == 0) begin
          mode[i] = ($urandom_range(0, 1) == 0) ? BLK : int'($urandom_range(1, 3));
          hold[i] = ($urandom_range(0, 7) == 0) ? 25 : int'($urandom_range(1, 20));
        end
        hold[i]--;
        set_ch(i, mode[i]);
      end
      if ($urandom_range(0, 99) == 0)
        ch_en = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'($urandom_range(0, 3));
      clear = ($urandom_range(0, 249) == 0);
      tick(1);
    end
    clear = 1'b0;
    tick(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
